// File: rtl/data_pipe_pkg.sv
// Shared types for the data_pipe width converters.
// Holds the pipe state enum and the lane index width helper.
package data_pipe_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } pipe_state_e;

  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_pipe_nto1.sv
// Wide-to-narrow pipe: one DSIZE*NSIZE word in, up to NSIZE lanes out.
// Ports: clock, rst_n, wr_* wide side (vld/ready/num/last), rd_* narrow side.
module data_pipe_nto1
  import data_pipe_pkg::*;
#(
  parameter  int DSIZE = 4,
  parameter  int NSIZE = 2,
  localparam int CSIZE = lane_bits(NSIZE)
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [DSIZE*NSIZE-1:0] wr_data,
  input  logic                   wr_vld,
  output logic                   wr_ready,
  input  logic [CSIZE-1:0]       wr_num,
  input  logic                   wr_last,
  output logic [DSIZE-1:0]       rd_data,
  output logic                   rd_vld,
  input  logic                   rd_ready,
  output logic                   rd_last
);

  localparam int WSIZE = DSIZE * NSIZE;
  localparam logic [CSIZE-1:0] TOP_MAX =
    CSIZE'(NSIZE - 1);

  pipe_state_e      state, state_nxt;
  logic [WSIZE-1:0] sreg, sreg_nxt;
  logic [CSIZE-1:0] cnt, cnt_nxt;
  logic [CSIZE-1:0] top, top_nxt;
  logic             lst, lst_nxt;

  logic             fin;
  logic             wr_acc;
  logic             rd_acc;
  logic [CSIZE-1:0] num_clamp;

  assign fin       = (cnt == top);
  assign rd_vld    = (state == BUSY);
  assign rd_data   = sreg[DSIZE-1:0];
  assign rd_last   = lst && fin && rd_vld;
  // Reload is allowed while the final lane leaves.
  assign wr_ready  = rst_n &&
                     ((state == EMPTY) ||
                      (fin && rd_ready));
  assign wr_acc    = wr_vld && wr_ready;
  assign rd_acc    = rd_vld && rd_ready;
  assign num_clamp = (wr_num > TOP_MAX) ?
                     TOP_MAX : wr_num;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    top_nxt   = top;
    lst_nxt   = lst;
    if (rd_acc) begin
      if (fin) begin
        state_nxt = EMPTY;
      end else begin
        sreg_nxt = sreg >> DSIZE;
        cnt_nxt  = cnt + CSIZE'(1);
      end
    end
    // A write only lands when EMPTY or on the final
    // lane, so it never collides with a shift.
    if (wr_acc) begin
      state_nxt = BUSY;
      sreg_nxt  = wr_data;
      cnt_nxt   = '0;
      top_nxt   = num_clamp;
      lst_nxt   = wr_last;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      sreg  <= '0;
      cnt   <= '0;
      top   <= '0;
      lst   <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      top   <= top_nxt;
      lst   <= lst_nxt;
    end
  end

endmodule

// File: doc/data_pipe_nto1.md
# data_pipe_nto1

Width-reduction pipe that accepts one DSIZE*NSIZE-bit word per valid/ready handshake and emits it as up to NSIZE consecutive DSIZE-bit words on a second valid/ready interface. It sits directly downstream of data_pipe_1ton in the same clock domain and restores the narrow stream that data_pipe_1ton packed. It also unpacks partial final words, emitting only the valid lanes, and carries a last marker through to the narrow side.

## Interface
Parameters:
- DSIZE, 4, narrow lane width in bits (≥1)
- NSIZE, 2, lanes per wide word (≥1)
- CSIZE, derived = max(1, $clog2(NSIZE)), lane index width; not overridable

Ports:
- clock  input  1  single clock; all logic on posedge
- rst_n  input  1  asynchronous active-low reset; asserts asynchronously, releases synchronously to clock
- wr_data  input  DSIZE*NSIZE  wide word; lane i = wr_data[i*DSIZE +: DSIZE]
- wr_vld  input  1  wide word valid
- wr_ready  output  1  block can take a wide word this cycle
- wr_num  input  CSIZE  index of the highest valid lane (valid lanes = wr_num+1); values ≥NSIZE are treated as NSIZE-1
- wr_last  input  1  word is the final word of a packet
- rd_data  output  DSIZE  narrow word, registered
- rd_vld  output  1  narrow word valid, registered
- rd_ready  input  1  downstream accepts
- rd_last  output  1  qualifies rd_vld; marks the final lane of a wr_last word

## Operation
- Storage: shift register sreg (DSIZE*NSIZE), lane counter cnt (CSIZE), top-lane register top (CSIZE), last flag lst.
- States:
  - EMPTY: rd_vld=0.
  - BUSY: rd_vld=1.
- Write accept: wr_vld && wr_ready. On accept:
  - sreg <= wr_data
  - cnt <= 0
  - top <= clamped wr_num
  - lst <= wr_last
  - next state BUSY
- Read accept: rd_vld && rd_ready.
  - If cnt != top: sreg shifts right by DSIZE and cnt increments.
  - If cnt == top (final lane): go EMPTY, unless a write accept happens in the same cycle, in which case the new word loads and the state stays BUSY.
- wr_ready = rst_n && (EMPTY || (cnt==top && rd_ready)). Combinational from state and rd_ready; no path from wr_vld.
- rd_data = sreg[DSIZE-1:0]. Lane 0 is emitted first, lane top last. Lanes above top are never emitted.
- rd_last = lst && cnt==top && rd_vld.
- NSIZE=1: the block is a one-entry register slice; cnt and top are always 0.

## Timing
- Reset values: rd_vld=0, rd_last=0, rd_data=0, sreg=0, cnt=0, top=0, lst=0, state EMPTY. wr_ready=0 while rst_n=0 and 1 on the first cycle after release.
- Latency: a word accepted at edge k gives rd_vld=1 with lane 0 after edge k (cycle k+1).
- Throughput: with rd_ready held at 1, one narrow word per cycle with no bubble between wide words. wr_ready pulses high once every (wr_num+1) cycles.
- Stall: while rd_vld && !rd_ready, rd_data, rd_last and all internal state hold stable, and wr_ready=0 (except when EMPTY).
- Simultaneous final-lane read and write accept: the new word's lane 0 is presented on the next cycle and rd_vld does not drop.
- wr_vld without wr_ready: ignored; the upstream must hold wr_data, wr_num and wr_last.
- Reset mid-word: remaining lanes are discarded, outputs return to reset values immediately, and there is no output after release until a new write accept.
- No overflow or underflow is possible: writes are gated by wr_ready and rd_vld is only high in BUSY.

## Structure
- Shared package data_pipe_pkg holds the pipe_state_e enum {EMPTY, BUSY} and a function lane_bits(NSIZE) returning CSIZE. data_pipe_1ton imports the same package.
- Single flat module, no sub-modules. The wr_num clamp is an inline comparison.

## Test plan
All cases use DSIZE=4, NSIZE=2 unless stated.
- Streaming: write 8'h21, 8'h43, 8'h65 (wr_num=1) with wr_vld held and rd_ready=1 → rd_data 1,2,3,4,5,6 on consecutive cycles, rd_vld continuous; wr_ready sequence 1,0,1,0,1.
- Backpressure: write 8'hBA, rd_ready=0 for 5 cycles → rd_data=A stable, wr_ready=0 throughout; then rd_ready=1 → A, B, then rd_vld=0.
- Partial last: write 8'h57 with wr_num=0 and wr_last=1 → exactly one output 7 with rd_last=1; the 5 is never emitted.
- Last on full word: write 8'hDC with wr_last=1 → C with rd_last=0, then D with rd_last=1.
- Reset mid-word: write 8'h98, pull rst_n low after the first output 8 → rd_vld=0 immediately; after release, no output until the next write; 9 is never emitted.
- NSIZE=4 instance: write 16'h4321 with wr_num=2 → outputs 1, 2, 3 and wr_ready reasserts on the third output with rd_ready=1; the 4 is never emitted.
